// File: rtl/mig_app_pkg.sv
// Shared constants and command decode for the MIG app_* interface.
// Used by both the responder and the initiator side.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  localparam int unsigned ADDR_LSB   = 3;
  localparam int unsigned MASK_WIDTH = 64;

  typedef enum logic [1:0] {
    CmdKindWrite,
    CmdKindRead,
    CmdKindBad
  } cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [2:0] cmd);
    if (cmd == CMD_WRITE) return CmdKindWrite;
    if (cmd == CMD_READ)  return CmdKindRead;
    return CmdKindBad;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] store [Depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(Depth));
  assign empty   = (count == '0);
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mig_app_responder.sv
// Memory-controller end of the MIG app_* interface: on-chip word array with
// byte-masked writes, fixed-latency in-order reads and configurable app_rdy stalls.
module mig_app_responder
  import mig_app_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 30,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned CALIB_CYCLES = 16,
  parameter int unsigned STALL_PERIOD = 64,
  parameter int unsigned STALL_LEN    = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_calib_complete_o,
  input  logic                  app_en_i,
  input  logic [2:0]            app_cmd_i,
  input  logic [ADDR_WIDTH-1:0] app_addr_i,
  output logic                  app_rdy_o,
  input  logic                  app_wdf_wren_i,
  input  logic [DATA_WIDTH-1:0] app_wdf_data_i,
  input  logic                  app_wdf_end_i,
  input  logic [MASK_WIDTH-1:0] app_wdf_mask_i,
  output logic                  app_wdf_rdy_o,
  output logic                  app_rd_data_valid_o,
  output logic [DATA_WIDTH-1:0] app_rd_data_o,
  output logic                  app_rd_data_end_o,
  output logic                  bad_cmd_o
);

  localparam int unsigned DEPTH       = 1 << MEM_AW;
  localparam int unsigned CCW         = (CALIB_CYCLES > 0) ? $clog2(CALIB_CYCLES + 1) : 1;
  localparam int unsigned SCW         = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int unsigned STALL_START = (STALL_PERIOD > STALL_LEN) ? STALL_PERIOD - STALL_LEN : 0;
  localparam int unsigned WD_W        = MASK_WIDTH + DATA_WIDTH;
  localparam int unsigned NBYTES      = DATA_WIDTH / 8;

  logic                  calib;
  logic [CCW-1:0]        calib_cnt;
  logic [SCW-1:0]        stall_cnt;
  logic                  stall;
  logic                  bad_cmd;

  logic [MEM_AW-1:0]     cmd_idx;
  cmd_kind_e             kind;
  logic                  cmd_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  bad_acc;
  logic                  wdata_acc;

  logic                  wcmd_full;
  logic                  wcmd_empty;
  logic [MEM_AW-1:0]     wcmd_idx;
  logic                  wdata_full;
  logic                  wdata_empty;
  logic [WD_W-1:0]       wdata_out;
  logic [MASK_WIDTH-1:0] commit_mask;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  commit;

  logic                  hold_valid;
  logic [MEM_AW-1:0]     hold_idx;
  logic                  park;
  logic                  launch;
  logic [MEM_AW-1:0]     launch_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  logic                  unused_bits;

  // Only the word-index bits select the array; the rest alias.
  assign cmd_idx     = app_addr_i[MEM_AW+ADDR_LSB-1:ADDR_LSB];
  assign unused_bits = ^{app_addr_i[ADDR_WIDTH-1:MEM_AW+ADDR_LSB],
                         app_addr_i[ADDR_LSB-1:0], app_wdf_end_i};

  assign kind      = decode_cmd(app_cmd_i);
  assign stall     = (STALL_PERIOD != 0) && (32'(stall_cnt) >= STALL_START);
  assign app_rdy_o = calib && !stall && !wcmd_full && !hold_valid;
  assign app_wdf_rdy_o = calib && !wdata_full;

  assign cmd_acc   = app_en_i && app_rdy_o;
  assign wr_acc    = cmd_acc && (kind == CmdKindWrite);
  assign rd_acc    = cmd_acc && (kind == CmdKindRead);
  assign bad_acc   = cmd_acc && (kind == CmdKindBad);
  assign wdata_acc = app_wdf_wren_i && app_wdf_rdy_o;

  assign commit      = !wcmd_empty && !wdata_empty;
  assign commit_mask = wdata_out[WD_W-1 -: MASK_WIDTH];
  assign commit_data = wdata_out[DATA_WIDTH-1:0];

  // Reads wait behind any queued write so read-after-write order holds.
  assign park       = rd_acc && !wcmd_empty;
  assign launch     = wcmd_empty && (rd_acc || hold_valid);
  assign launch_idx = hold_valid ? hold_idx : cmd_idx;

  sync_fifo #(
    .Width (MEM_AW),
    .Depth (FIFO_DEPTH)
  ) u_wcmd_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (wr_acc),
    .wdata (cmd_idx),
    .pop   (commit),
    .rdata (wcmd_idx),
    .full  (wcmd_full),
    .empty (wcmd_empty)
  );

  sync_fifo #(
    .Width (WD_W),
    .Depth (FIFO_DEPTH)
  ) u_wdata_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (wdata_acc),
    .wdata ({app_wdf_mask_i, app_wdf_data_i}),
    .pop   (commit),
    .rdata (wdata_out),
    .full  (wdata_full),
    .empty (wdata_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      calib     <= 1'b0;
      calib_cnt <= '0;
      stall_cnt <= '0;
      bad_cmd   <= 1'b0;
    end else begin
      if (!calib) begin
        if (32'(calib_cnt) + 32'd1 >= CALIB_CYCLES) calib <= 1'b1;
        else calib_cnt <= calib_cnt + CCW'(1);
      end
      if (calib && (STALL_PERIOD != 0)) begin
        stall_cnt <= (stall_cnt == SCW'(STALL_PERIOD - 1)) ? '0 : stall_cnt + SCW'(1);
      end
      if (bad_acc) bad_cmd <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_idx   <= '0;
    end else if (park) begin
      hold_valid <= 1'b1;
      hold_idx   <= cmd_idx;
    end else if (hold_valid && wcmd_empty) begin
      hold_valid <= 1'b0;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (!commit_mask[b]) mem[wcmd_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= launch;
      if (launch) pipe_data[0] <= mem[launch_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign init_calib_complete_o = calib;
  assign app_rd_data_valid_o   = pipe_valid[RD_LATENCY-1];
  assign app_rd_data_o         = pipe_data[RD_LATENCY-1];
  assign app_rd_data_end_o     = pipe_valid[RD_LATENCY-1];
  assign bad_cmd_o             = bad_cmd;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: a byte-level memory model feeds a
// scoreboard queue of expected read returns, compared as the DUT returns data.
module tb_mig_app_responder;
  import mig_app_pkg::*;

  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 512;
  localparam int unsigned MAW = 10;
  localparam int unsigned RDL = 4;
  localparam int unsigned CAL = 16;
  localparam int unsigned SP  = 8;
  localparam int unsigned SL  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          calib;
  logic          app_en = 1'b0;
  logic [2:0]    app_cmd = '0;
  logic [AW-1:0] app_addr = '0;
  logic          app_rdy;
  logic          app_wren = 1'b0;
  logic [DW-1:0] app_wdata = '0;
  logic          app_wend = 1'b1;
  logic [63:0]   app_mask = '0;
  logic          app_wdf_rdy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_end;
  logic          bad_cmd;

  mig_app_responder #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_AW       (MAW),
    .RD_LATENCY   (RDL),
    .CALIB_CYCLES (CAL),
    .STALL_PERIOD (SP),
    .STALL_LEN    (SL),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .init_calib_complete_o (calib),
    .app_en_i              (app_en),
    .app_cmd_i             (app_cmd),
    .app_addr_i            (app_addr),
    .app_rdy_o             (app_rdy),
    .app_wdf_wren_i        (app_wren),
    .app_wdf_data_i        (app_wdata),
    .app_wdf_end_i         (app_wend),
    .app_wdf_mask_i        (app_mask),
    .app_wdf_rdy_o         (app_wdf_rdy),
    .app_rd_data_valid_o   (rd_valid),
    .app_rd_data_o         (rd_data),
    .app_rd_data_end_o     (rd_end),
    .bad_cmd_o             (bad_cmd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   acc;
    bit            chk_lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [1 << MAW];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAW-1:0] widx(input logic [AW-1:0] a);
    return a[MAW+2:3];
  endfunction

  function automatic void model_apply(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [63:0] m);
    for (int b = 0; b < 64; b++) begin
      if (!m[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a,
                        output int unsigned acc, output bit ok);
    int n = 0;
    @(negedge clk);
    app_wren = 1'b0;
    app_en   = 1'b1;
    app_cmd  = c;
    app_addr = a;
    while (!app_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok  = app_rdy;
    acc = cyc + 1;
    if (!ok) begin
      chk("cmd_rdy_timeout", app_rdy, 1'b1);
      app_en = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic do_wdata(input logic [DW-1:0] d, input logic [63:0] m);
    int n = 0;
    @(negedge clk);
    app_en    = 1'b0;
    app_wren  = 1'b1;
    app_wdata = d;
    app_mask  = m;
    while (!app_wdf_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!app_wdf_rdy) begin
      chk("wdata_rdy_timeout", app_wdf_rdy, 1'b1);
      app_wren = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic wr_cmd(input logic [AW-1:0] a);
    int unsigned acc;
    bit ok;
    do_cmd(CMD_WRITE, a, acc, ok);
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit lat);
    int unsigned acc;
    bit ok;
    do_cmd(CMD_READ, a, acc, ok);
    if (ok) sb.push_back('{data: model[widx(a)], acc: acc, chk_lat: lat});
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [63:0] m);
    wr_cmd(a);
    do_wdata(d, m);
    model_apply(a, d, m);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    app_en   = 1'b0;
    app_wren = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", rd_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_end", rd_end, 1'b1);
        if (e.chk_lat) chk("rd_latency", cyc - e.acc, RDL - 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d [3];
    logic [DW-1:0] a5;
    int lows, run, maxrun, wdf_hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_calib", calib, 1'b0);
    chk("rst_rdy", app_rdy, 1'b0);
    chk("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, '0);
    chk("rst_end", rd_end, 1'b0);
    chk("rst_bad", bad_cmd, 1'b0);

    // Calibration rises exactly CAL cycles after release
    rst = 1'b0;
    for (int k = 1; k <= CAL; k++) begin
      @(negedge clk);
      chk($sformatf("calib_k%0d", k), calib, (k == CAL));
      if (k < CAL) begin
        chk("precal_rdy", app_rdy, 1'b0);
        chk("precal_wdf_rdy", app_wdf_rdy, 1'b0);
        chk("precal_valid", rd_valid, 1'b0);
        chk("precal_bad", bad_cmd, 1'b0);
      end
    end

    // Stall pattern: SL low cycles in every SP, wdf_rdy unaffected
    lows = 0; run = 0; maxrun = 0; wdf_hi = 0;
    for (int k = 0; k < 8 * SP; k++) begin
      @(negedge clk);
      if (!app_rdy) begin
        lows++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (app_wdf_rdy) wdf_hi++;
    end
    chk("stall_low_count", lows, 8 * SL);
    chk("stall_run_len", maxrun, SL);
    chk("wdf_rdy_in_stall", wdf_hi, 8 * SP);

    // Single write then read
    a5 = {16{32'hA5A5_A5A5}};
    write(30'h18, a5, '0);
    idle(4);
    rd(30'h18, 1'b1);
    idle(1);
    drain("drain_single");

    // Data leading command
    for (int i = 0; i < 3; i++) begin
      d[i] = rand_word();
      do_wdata(d[i], '0);
    end
    for (int i = 0; i < 3; i++) begin
      wr_cmd(30'(8 * i));
      model_apply(30'(8 * i), d[i], '0);
    end
    for (int i = 0; i < 3; i++) rd(30'(8 * i), 1'b0);
    idle(1);
    drain("drain_lead");

    // Byte mask: only byte 0 written
    write(30'h100, {DW{1'b1}}, '0);
    write(30'h100, '0, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(4);
    rd(30'h100, 1'b1);
    idle(1);
    drain("drain_mask");

    // RAW hazard: read parked behind a write whose data is withheld
    write(30'h40, rand_word(), '0);
    idle(4);
    wr_cmd(30'h40);
    idle(2);
    d[0] = rand_word();
    model_apply(30'h40, d[0], '0);
    rd(30'h40, 1'b0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      chk("raw_hold_rdy", app_rdy, 1'b0);
      @(negedge clk);
    end
    chk("raw_hold_rdy", app_rdy, 1'b0);
    do_wdata(d[0], '0);
    idle(1);
    drain("drain_raw");

    // Address aliasing modulo array depth
    d[1] = rand_word();
    write(30'h8, d[1], '0);
    idle(4);
    rd(30'((1 << 13) + 8), 1'b1);
    d[2] = rand_word();
    write(30'((1 << 14) + 16), d[2], '0);
    idle(4);
    rd(30'h10, 1'b1);
    idle(1);
    drain("drain_alias");

    // Illegal command: sticky flag, no memory effect
    chk("bad_before", bad_cmd, 1'b0);
    begin
      int unsigned acc;
      bit ok;
      do_cmd(3'd3, 30'h18, acc, ok);
    end
    idle(3);
    chk("bad_after", bad_cmd, 1'b1);
    rd(30'h18, 1'b1);
    idle(1);
    drain("drain_bad");

    // 100 streamed reads through stall windows
    for (int i = 0; i < 100; i++) write(30'(8 * i), rand_word(), '0);
    idle(8);
    for (int i = 0; i < 100; i++) rd(30'(8 * i), 1'b1);
    idle(1);
    drain("drain_stream");
    chk("bad_still_set", bad_cmd, 1'b1);

    // Reset mid-flight drops reads and restarts calibration
    rd(30'h18, 1'b1);
    rd(30'h20, 1'b1);
    @(negedge clk);
    app_en = 1'b0;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("midrst_valid", rd_valid, 1'b0);
    chk("midrst_bad", bad_cmd, 1'b0);
    chk("midrst_calib", calib, 1'b0);
    rst = 1'b0;
    repeat (CAL - 1) @(negedge clk);
    chk("recal_early", calib, 1'b0);
    @(negedge clk);
    chk("recal_done", calib, 1'b1);
    idle(10);
    chk("after_rst_valid", rd_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
